// File: rtl/fp_to_int_converter.sv
// rtl/fp_to_int_converter.sv - IEEE-754 single to signed int32, iterative one-bit shifter
// Optional feature macro: FP2INT_ROUND_EN (round to nearest even; default truncates toward zero)
module fp_to_int_converter (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [1:0]  out_flags
);
   typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

   state_t      state;
   logic [31:0] mag;
   logic [4:0]  cnt;
   logic        left;
   logic        sign_r;
   logic        guard;
   logic        sticky;
   logic        bypass;

   logic               in_sign;
   logic [7:0]         in_exp;
   logic [22:0]        in_frac;
   logic signed [8:0]  e;
   logic               is_nan;
   logic               is_ovf;
   logic               is_neg_min;
   logic               is_zero_exp;
   logic               is_small;
   logic               left_init;
   logic [4:0]         n_init;
   logic [31:0]        sat_val;
   logic [31:0]        mag_rnd;

   assign in_sign     = in_data[31];
   assign in_exp      = in_data[30:23];
   assign in_frac     = in_data[22:0];
   assign e           = $signed({1'b0, in_exp}) - 9'sd127;
   assign is_nan      = (in_exp == 8'hFF) && (in_frac != 23'd0);
   assign is_ovf      = (in_exp == 8'hFF) || (e >= 9'sd31);
   assign is_neg_min  = (in_data == 32'hCF00_0000);
   assign is_zero_exp = (in_exp == 8'h00);
   assign sat_val     = in_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

   // Shift distance |e - 23| computed on the low 5 exponent bits (e - 23 == exp - 150, 150 mod 32 == 22)
   assign left_init = (in_exp >= 8'd150);
   assign n_init    = left_init ? (in_exp[4:0] - 5'd22) : (5'd22 - in_exp[4:0]);

`ifdef FP2INT_ROUND_EN
   // e == -1 still reaches the shifter so 0.5..1.0 can round up to 1
   assign is_small = (e < -9'sd1);
   assign mag_rnd  = mag + {31'd0, guard & (sticky | mag[0])};
`else
   assign is_small = (e < 9'sd0);
   assign mag_rnd  = mag;
`endif

   // Control FSM with all datapath registers and registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= 32'd0;
         out_flags <= 2'b00;
         mag       <= 32'd0;
         cnt       <= 5'd0;
         left      <= 1'b0;
         sign_r    <= 1'b0;
         guard     <= 1'b0;
         sticky    <= 1'b0;
         bypass    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  sign_r   <= in_sign;
                  guard    <= 1'b0;
                  sticky   <= 1'b0;
                  cnt      <= 5'd0;
                  left     <= 1'b0;
                  mag      <= 32'd0;
                  bypass   <= 1'b1;
                  state    <= SIGN;
                  if (is_nan) begin
                     out_data  <= 32'h8000_0000;
                     out_flags <= 2'b10;
                  end else if (is_neg_min) begin
                     out_data  <= 32'h8000_0000;
                     out_flags <= 2'b00;
                  end else if (is_ovf) begin
                     out_data  <= sat_val;
                     out_flags <= 2'b10;
                  end else if (is_zero_exp) begin
                     out_data  <= 32'd0;
                     out_flags <= {1'b0, in_frac != 23'd0};
                  end else if (is_small) begin
                     out_data  <= 32'd0;
                     out_flags <= 2'b01;
                  end else begin
                     bypass <= 1'b0;
                     mag    <= {8'd0, 1'b1, in_frac};
                     cnt    <= n_init;
                     left   <= left_init;
                     state  <= (n_init == 5'd0) ? SIGN : SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (left) begin
                  mag <= mag << 1;
               end else begin
                  mag    <= mag >> 1;
                  guard  <= mag[0];
                  sticky <= sticky | guard;
               end
               cnt <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  state <= SIGN;
               end
            end
            SIGN: begin
               if (!bypass) begin
                  out_data  <= sign_r ? (32'd0 - mag_rnd) : mag_rnd;
                  out_flags <= {1'b0, guard | sticky};
               end
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fp_to_int_converter.sv
// tb/tb_fp_to_int_converter.sv - scoreboard bench for fp_to_int_converter
module tb_fp_to_int_converter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [1:0]  out_flags;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  flags;
      int          lat;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          accept_cyc = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] held_data = 32'd0;
   logic [1:0]  held_flags = 2'b00;

   always #5 clk = ~clk;

   fp_to_int_converter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %h required %h", nm, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on each new result, checks hold-stability while stalled
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (in_valid && in_ready) accept_cyc = cyc + 1;
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual %h required none", out_data);
            end else begin
               cur = sb.pop_front();
               check({cur.name, "_data"}, out_data, cur.data);
               check({cur.name, "_flags"}, {30'd0, out_flags}, {30'd0, cur.flags});
               check({cur.name, "_latency"}, cyc - accept_cyc, cur.lat);
            end
            held_data  = out_data;
            held_flags = out_flags;
         end else if (out_valid) begin
            check("hold_data", out_data, held_data);
            check("hold_flags", {30'd0, out_flags}, {30'd0, held_flags});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
         end
         prev_valid = out_valid;
      end
   end

   task automatic issue(input logic [31:0] d, input logic [31:0] xd, input logic [1:0] xf,
                        input int lat, input string nm);
      exp_t x;
      int   n;
      n       = 0;
      x.data  = xd;
      x.flags = xf;
      x.lat   = lat;
      x.name  = nm;
      sb.push_back(x);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s_accept_timeout actual in_ready=0 required 1", nm);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
      end
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("reset_out_flags", {30'd0, out_flags}, 32'd0);
      rst = 1'b0;

      issue(32'h3F80_0000, 32'h0000_0001, 2'b00, 24, "one");
      issue(32'h4B00_0000, 32'h0080_0000, 2'b00, 1,  "two_pow23");
      issue(32'hC2F6_E979, 32'hFFFF_FF85, 2'b01, 18, "neg_123");
      issue(32'h4F00_0000, 32'h7FFF_FFFF, 2'b10, 1,  "pos_2pow31");
      issue(32'hCF00_0000, 32'h8000_0000, 2'b00, 1,  "neg_2pow31");
      issue(32'h7FC0_0000, 32'h8000_0000, 2'b10, 1,  "nan");
      issue(32'h0000_0001, 32'h0000_0000, 2'b01, 1,  "denormal");
      issue(32'hFF80_0000, 32'h8000_0000, 2'b10, 1,  "neg_inf");
      issue(32'h4EFF_FFFF, 32'h7FFF_FF80, 2'b00, 8,  "max_e30");
      issue(32'h4020_0000, 32'h0000_0002, 2'b01, 23, "two_p5");
`ifdef FP2INT_ROUND_EN
      issue(32'h3FC0_0000, 32'h0000_0002, 2'b01, 24, "one_p5");
      issue(32'hBFC0_0000, 32'hFFFF_FFFE, 2'b01, 24, "neg_one_p5");
      issue(32'h3F40_0000, 32'h0000_0001, 2'b01, 25, "zero_p75");
      issue(32'h3F00_0000, 32'h0000_0000, 2'b01, 25, "zero_p5");
`else
      issue(32'h3FC0_0000, 32'h0000_0001, 2'b01, 24, "one_p5");
      issue(32'hBFC0_0000, 32'hFFFF_FFFF, 2'b01, 24, "neg_one_p5");
      issue(32'h3F40_0000, 32'h0000_0000, 2'b01, 1,  "zero_p75");
      issue(32'h3F00_0000, 32'h0000_0000, 2'b01, 1,  "zero_p5");
`endif
      drain();

      // Backpressure: stall DONE for 5 cycles with a second operand waiting
      out_ready = 1'b0;
      issue(32'h4040_0000, 32'h0000_0003, 2'b00, 23, "bp_first");
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
      begin
         exp_t x;
         x.data  = 32'h0000_000A;
         x.flags = 2'b00;
         x.lat   = 21;
         x.name  = "bp_second";
         sb.push_back(x);
      end
      in_valid = 1'b1;
      in_data  = 32'h4120_0000;
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
         check("bp_data_stable", out_data, 32'h0000_0003);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_completion_in_ready", {31'd0, in_ready}, 32'd1);
      check("bp_completion_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
      drain();

      // Reset in the middle of a shift sequence
      issue(32'h3F80_0000, 32'h0000_0001, 2'b00, 24, "rst_victim");
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      void'(sb.pop_back());
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
      issue(32'h4040_0000, 32'h0000_0003, 2'b00, 23, "after_rst");
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required completion");
      $fatal(1, "watchdog");
   end
endmodule
